// File: rtl/manchester_decoder_if.sv
// -----------------------------------------------------------------------------
// manchester_decoder_if
//   Bundles the Manchester line input and the recovered-bit outputs of
//   manchester_decoder.
//
//   Signals:
//     line_in    : asynchronous Manchester line (line side -> decoder)
//     data_out   : recovered NRZ bit, meaningful while data_valid=1
//     data_valid : one-cycle pulse per decoded bit
//     locked     : high while the decoder tracks bit timing
//     code_err   : one-cycle pulse on a coding/timing violation
//
//   Modports:
//     master : line side / consumer (drives line_in, observes results)
//     slave  : the decoder itself
// -----------------------------------------------------------------------------
interface manchester_decoder_if;
    logic line_in;
    logic data_out;
    logic data_valid;
    logic locked;
    logic code_err;

    modport master (
        output line_in,
        input  data_out,
        input  data_valid,
        input  locked,
        input  code_err
    );

    modport slave (
        input  line_in,
        output data_out,
        output data_valid,
        output locked,
        output code_err
    );
endinterface

// File: rtl/manchester_decoder.sv
// -----------------------------------------------------------------------------
// manchester_decoder
//   Recovers NRZ data and bit timing from an oversampled Manchester line.
//   Bit 1 = low then high (rising mid-bit edge), bit 0 = high then low
//   (falling mid-bit edge).
//
//   Parameters:
//     OVS : clk cycles per Manchester bit (multiple of 4, >= 8); Q = OVS/4
//     CW  : interval counter width, 2**CW > 5*Q+1
//
//   Ports:
//     clk : clock, all logic on the rising edge
//     rst : synchronous, active-high reset
//     bus : manchester_decoder_if.slave
//             line_in (in), data_out, data_valid, locked, code_err (out)
// -----------------------------------------------------------------------------
module manchester_decoder #(
    parameter int unsigned OVS = 16,
    parameter int unsigned CW  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    manchester_decoder_if.slave  bus
);

    localparam int unsigned Q = OVS / 4;

    // Interval thresholds, measured in cycles since the last accepted edge.
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] LIM_BND  = CW'(Q);          // below: too early
    localparam logic [CW-1:0] LIM_MID  = CW'(3 * Q);      // mid-bit window start
    localparam logic [CW-1:0] LIM_HI   = CW'(5 * Q);      // mid-bit window end
    localparam logic [CW-1:0] LIM_TO   = CW'(5 * Q + 1);  // missing transition
    localparam logic [CW-1:0] CNT_MAX  = '1;

    localparam logic [0:0] HUNT  = 1'b0;
    localparam logic [0:0] TRACK = 1'b1;

    // Input synchronizer and history flop.
    logic s1, s2, s3;
    logic line_edge;

    // State.
    logic [0:0]    state,      state_n;
    logic [CW-1:0] cnt,        cnt_n;
    logic          seen_bnd,   seen_bnd_n;
    logic          seen_edge,  seen_edge_n;
    logic          data_out_r, data_out_n;
    logic          dv_r,       dv_n;
    logic          err_r,      err_n;

    // Edge classification of the current interval.
    logic          in_bnd, in_mid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.line_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign line_edge = s2 ^ s3;
    assign in_bnd    = (cnt >= LIM_BND) && (cnt < LIM_MID);
    assign in_mid    = (cnt >= LIM_MID) && (cnt <= LIM_HI);

    always_comb begin
        state_n     = state;
        cnt_n       = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
        seen_bnd_n  = seen_bnd;
        seen_edge_n = seen_edge;
        data_out_n  = data_out_r;
        dv_n        = 1'b0;
        err_n       = 1'b0;

        case (state)
            HUNT: begin
                if (line_edge) begin
                    cnt_n = CNT_ONE;
                    // A qualifying interval needs a reference edge seen since
                    // entering HUNT; otherwise this edge only starts a measurement.
                    if (seen_edge && in_mid) begin
                        state_n     = TRACK;
                        dv_n        = 1'b1;
                        data_out_n  = s2;
                        seen_bnd_n  = 1'b0;
                        seen_edge_n = 1'b0;
                    end else begin
                        seen_edge_n = 1'b1;
                    end
                end
            end

            default: begin // TRACK
                // Timeout has priority: an edge at 5Q+1 is just as late as none.
                if (cnt >= LIM_TO) begin
                    err_n = 1'b1;
                end else if (line_edge) begin
                    if (cnt < LIM_BND) begin
                        err_n = 1'b1;
                    end else if (in_bnd) begin
                        if (seen_bnd) begin
                            err_n = 1'b1;
                        end else begin
                            seen_bnd_n = 1'b1;
                        end
                    end else if (in_mid) begin
                        dv_n       = 1'b1;
                        data_out_n = s2;
                        cnt_n      = CNT_ONE;
                        seen_bnd_n = 1'b0;
                    end
                end

                if (err_n) begin
                    state_n     = HUNT;
                    cnt_n       = '0;
                    seen_bnd_n  = 1'b0;
                    seen_edge_n = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            cnt        <= '0;
            seen_bnd   <= 1'b0;
            seen_edge  <= 1'b0;
            data_out_r <= 1'b0;
            dv_r       <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            seen_bnd   <= seen_bnd_n;
            seen_edge  <= seen_edge_n;
            data_out_r <= data_out_n;
            dv_r       <= dv_n;
            err_r      <= err_n;
        end
    end

    assign bus.data_out   = data_out_r;
    assign bus.data_valid = dv_r;
    assign bus.code_err   = err_r;
    assign bus.locked     = (state == TRACK);

endmodule

// File: tb/tb_manchester_decoder.sv
// -----------------------------------------------------------------------------
// tb_manchester_decoder
//   Directed bench for manchester_decoder (OVS=16, CW=8, Q=4).
//   Line changes are driven one tick after a rising edge; a change driven in
//   the gap after edge n shows up on the outputs after edge n+3. A drive
//   spacing of d between two edges measures as cnt=d inside the decoder.
// -----------------------------------------------------------------------------
module tb_manchester_decoder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    manchester_decoder_if bus_if ();

    manchester_decoder #(
        .OVS (16),
        .CW  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared   = 0;
    int mismatched = 0;

    // Observed events (cycle stamps), collected on the falling edge.
    int obs_dv_t[$];
    int obs_dv_d[$];
    int obs_err[$];
    int obs_rise[$];
    int obs_fall[$];
    logic lk_prev = 1'b0;

    // Expected events.
    int exp_dv_t[$];
    int exp_dv_d[$];
    int exp_err[$];
    int exp_rise[$];
    int exp_fall[$];

    always @(negedge clk) begin
        if (bus_if.data_valid === 1'b1) begin
            obs_dv_t.push_back(cyc);
            obs_dv_d.push_back((bus_if.data_out === 1'b1) ? 1 : 0);
        end
        if (bus_if.code_err === 1'b1) obs_err.push_back(cyc);
        if ((bus_if.locked === 1'b1) && !lk_prev) obs_rise.push_back(cyc);
        if ((bus_if.locked !== 1'b1) && lk_prev)  obs_fall.push_back(cyc);
        lk_prev = (bus_if.locked === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick(1);
    endtask

    task automatic drive_at(input int t, input logic v);
        wait_until(t);
        bus_if.line_in = v;
    endtask

    task automatic exp_bit(input int t, input int d);
        exp_dv_t.push_back(t);
        exp_dv_d.push_back(d);
    endtask

    task automatic exp_error(input int t);
        exp_err.push_back(t);
        exp_fall.push_back(t);
    endtask

    task automatic check_seg(input string tag);
        chk({tag, ".dv_count"}, obs_dv_t.size(), exp_dv_t.size());
        for (int i = 0; i < exp_dv_t.size(); i++) begin
            if (i < obs_dv_t.size()) begin
                chk($sformatf("%s.dv_time[%0d]", tag, i), obs_dv_t[i], exp_dv_t[i]);
                chk($sformatf("%s.dv_data[%0d]", tag, i), obs_dv_d[i], exp_dv_d[i]);
            end
        end
        chk({tag, ".err_count"}, obs_err.size(), exp_err.size());
        for (int i = 0; i < exp_err.size(); i++)
            if (i < obs_err.size())
                chk($sformatf("%s.err_time[%0d]", tag, i), obs_err[i], exp_err[i]);
        chk({tag, ".lock_rise_count"}, obs_rise.size(), exp_rise.size());
        for (int i = 0; i < exp_rise.size(); i++)
            if (i < obs_rise.size())
                chk($sformatf("%s.lock_rise[%0d]", tag, i), obs_rise[i], exp_rise[i]);
        chk({tag, ".lock_fall_count"}, obs_fall.size(), exp_fall.size());
        for (int i = 0; i < exp_fall.size(); i++)
            if (i < obs_fall.size())
                chk($sformatf("%s.lock_fall[%0d]", tag, i), obs_fall[i], exp_fall[i]);
        obs_dv_t.delete(); obs_dv_d.delete(); obs_err.delete();
        obs_rise.delete(); obs_fall.delete();
        exp_dv_t.delete(); exp_dv_d.delete(); exp_err.delete();
        exp_rise.delete(); exp_fall.delete();
    endtask

    // Hard time limit; the directed sequence needs well under 1000 cycles.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   r, t0, m, e, f, g, h, j;
        logic bits [12];
        bits = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset with line held high.
        rst = 1'b1;
        bus_if.line_in = 1'b1;
        tick(3);
        chk("rst.data_out",   bus_if.data_out,   1'b0);
        chk("rst.data_valid", bus_if.data_valid, 1'b0);
        chk("rst.locked",     bus_if.locked,     1'b0);
        chk("rst.code_err",   bus_if.code_err,   1'b0);
        obs_dv_t.delete(); obs_dv_d.delete(); obs_err.delete();
        obs_rise.delete(); obs_fall.delete();

        // Release: the synchronizer sees the high line as one edge; no lock, no error.
        rst = 1'b0;
        r = cyc + 30;
        wait_until(r);
        chk("release.locked", bus_if.locked, 1'b0);
        check_seg("release");

        // Line goes idle low, then 12 ideal bits. Lock on bit index 1.
        drive_at(r, 1'b0);
        t0 = r + 20;
        for (int i = 0; i < 12; i++) begin
            drive_at(t0 + 16 * i, !bits[i]);
            drive_at(t0 + 16 * i + 8, bits[i]);
            if (i >= 1) exp_bit(t0 + 16 * i + 11, bits[i] ? 1 : 0);
            if (i == 1) exp_rise.push_back(t0 + 16 * i + 11);
        end
        m = t0 + 184;
        wait_until(m + 4);
        check_seg("lock");

        // Jitter: mid-bit edges at cnt=12 and cnt=20 accepted, cnt=21 rejected.
        drive_at(m + 12, 1'b1);
        exp_bit(m + 15, 1);
        drive_at(m + 32, 1'b0);
        exp_bit(m + 35, 0);
        drive_at(m + 53, 1'b1);
        exp_error(m + 56);
        wait_until(m + 60);
        check_seg("jitter");

        // Relock, then hold the line constant: one timeout error.
        e = m + 72;
        drive_at(e, 1'b0);
        drive_at(e + 16, 1'b1);
        exp_bit(e + 19, 1);
        exp_rise.push_back(e + 19);
        exp_error(e + 40);
        wait_until(e + 70);
        check_seg("missing");

        // Relock on a fresh preamble, then a 1-cycle glitch at cnt=2.
        f = e + 76;
        drive_at(f, 1'b0);
        drive_at(f + 16, 1'b1);
        exp_bit(f + 19, 1);
        exp_rise.push_back(f + 19);
        drive_at(f + 32, 1'b0);
        exp_bit(f + 35, 0);
        drive_at(f + 34, 1'b1);
        drive_at(f + 35, 1'b0);
        exp_error(f + 37);
        wait_until(f + 50);
        check_seg("glitch_early");

        // Relock, then a pulse with edges at cnt=5 and cnt=7: double boundary.
        g = f + 60;
        drive_at(g, 1'b1);
        drive_at(g + 16, 1'b0);
        exp_bit(g + 19, 0);
        exp_rise.push_back(g + 19);
        drive_at(g + 21, 1'b1);
        drive_at(g + 23, 1'b0);
        exp_error(g + 26);
        wait_until(g + 35);
        check_seg("glitch_bnd");

        // Same glitches while hunting: nothing reported.
        h = g + 40;
        drive_at(h, 1'b1);
        drive_at(h + 1, 1'b0);
        drive_at(h + 10, 1'b1);
        drive_at(h + 12, 1'b0);
        wait_until(h + 30);
        chk("hunt.locked", bus_if.locked, 1'b0);
        check_seg("glitch_hunt");

        // Lock, reset for one cycle between bits, then a two-edge relock.
        j = h + 40;
        drive_at(j, 1'b1);
        drive_at(j + 16, 1'b0);
        exp_bit(j + 19, 0);
        exp_rise.push_back(j + 19);
        wait_until(j + 20);
        chk("pre_rst.locked", bus_if.locked, 1'b1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_rst.locked",     bus_if.locked,     1'b0);
        chk("mid_rst.data_out",   bus_if.data_out,   1'b0);
        chk("mid_rst.data_valid", bus_if.data_valid, 1'b0);
        chk("mid_rst.code_err",   bus_if.code_err,   1'b0);
        exp_fall.push_back(j + 21);
        drive_at(j + 32, 1'b1);
        drive_at(j + 48, 1'b0);
        exp_bit(j + 51, 0);
        exp_rise.push_back(j + 51);
        wait_until(j + 60);
        check_seg("rst_midstream");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/manchester_decoder.md
# manchester_decoder

Recovers NRZ data and bit timing from an asynchronous, oversampled Manchester line. This is the receive end of the NRZ-to-Manchester link, and it shares the same encoding convention. Bit 1 is low for the first half and high for the second half, giving a rising mid-bit edge. Bit 0 is high then low, giving a falling mid-bit edge. The block sits between the line pin and the bit-level consumer; it emits one validated bit per recovered bit period plus lock and error status.

## Interface
- OVS, 16: clk cycles per Manchester bit. Must be a multiple of 4 and ≥ 8. Q = OVS/4.
- CW, 8: width of the interval counter. Must satisfy 2^CW > 5·Q+1.

- clk  input  1  all logic on rising edge
- rst  input  1  reset: rst, synchronous, active-high; clears all state and outputs on the next clk edge
- line_in  input  1  asynchronous Manchester line
- data_out  output  1  recovered bit; valid only while data_valid=1
- data_valid  output  1  one-cycle pulse per decoded bit
- locked  output  1  high while in TRACK
- code_err  output  1  one-cycle pulse on a coding/timing violation

## Operation
- Input path: 2-FF synchronizer (s1, s2), then history FF s3. edge = s2 XOR s3; the new level is s2. All three flops reset to 0.
- cnt: cycles since the last accepted mid-bit edge (or, in HUNT, since the last edge). Loads 1 on that edge, increments every cycle, saturates at 2^CW−1.
- Edge classes in TRACK, by cnt at the edge:
  - cnt < Q: error.
  - Q ≤ cnt < 3Q: boundary edge.
  - 3Q ≤ cnt ≤ 5Q: mid-bit edge.
- FSM, 2 states:
  - HUNT (reset state, locked=0):
    - Any edge loads cnt=1.
    - If the edge arrived with 3Q ≤ cnt ≤ 5Q and a previous edge has been seen since entering HUNT, that edge is a mid-bit edge. Emit the bit and go to TRACK.
    - Edges arriving with cnt < 3Q or cnt > 5Q only restart measurement; no error in HUNT.
    - An alternating-bit preamble therefore locks on its second mid-bit edge. Bits before the locking edge are dropped.
  - TRACK (locked=1):
    - Mid-bit edge: data_out=s2 (rising→1, falling→0), data_valid pulse, cnt=1, clear seen_bnd.
    - Boundary edge: set seen_bnd. A second boundary edge while seen_bnd=1 is an error.
    - cnt reaching 5Q+1 with no mid-bit edge (missing transition) is an error.
    - Error: code_err pulse, go to HUNT, clear cnt and seen_bnd. No data_valid on the erroring cycle.
- At most one of data_valid and code_err is high in any cycle.

## Timing
- Reset values: data_out=0, data_valid=0, locked=0, code_err=0, state=HUNT, cnt=0, seen_bnd=0.
- Latency: the line change is first sampled into s1 at clk edge k. edge is true during cycle k+1. data_valid, data_out, locked and code_err update at edge k+2.
- Steady state: data_valid pulses every OVS cycles ±Q jitter. locked rises in the same cycle as the first data_valid.
- Timeout: code_err is asserted exactly 5Q+1 cycles after the last accepted mid-bit edge detection, plus the output-register cycle.
- rst during TRACK: the next edge gives locked=0 and all outputs 0. Relock requires a fresh two-edge measurement.
- Minimum detectable pulse: 1 cycle. Shorter pulses are filtered by sampling.

## Test plan
- Reset: hold line_in=1, assert rst 3 cycles → all outputs 0, locked=0. Release rst → no code_err; first measured edge does not lock.
- Lock/decode, OVS=16, ideal timing, line idle 0: send bits 1,0,1,0,1,0,1,0,1,1,0,0 → locked rises with data_valid for bit 2 (0). Then data_valid every 16 cycles with data_out=1,0,1,0,1,0,1,1,0,0; code_err never.
- Jitter: in locked stream, place mid-bit edges at cnt=12 and cnt=20 → both accepted with correct values. Mid-bit edge at cnt=21 → code_err at 21, locked=0.
- Missing transition: after lock, hold line constant 40 cycles → single code_err pulse, locked=0. Resume alternating preamble → relock after two mid-bit edges.
- Glitches, in TRACK: 1-cycle pulse at cnt=2 → code_err (edge < Q). Pulse at cnt=5/7 → second boundary edge → code_err. In HUNT, same glitches → no code_err.
- rst mid-stream: assert rst 1 cycle during TRACK between bits → locked=0 next cycle. No data_valid until two new mid-bit edges spaced 12–20 cycles.
